// File: rtl/rpn_key_sequencer.sv
// Keypad front end for an RPN stack calculator: turns key presses into push/op commands
// and tracks downstream stack depth so operations with too few operands are rejected.
module rpn_key_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic        cmd_valid,
  output logic        push,
  output logic [1:0]  op,
  output logic [15:0] d,
  output logic [15:0] entry,
  output logic [9:0]  depth,
  output logic        err
);

  localparam int unsigned DW = 16;
  localparam int unsigned SW = 10;
  localparam logic [SW-1:0] DEPTH_MAX = SW'(1023);

  localparam logic [3:0] K_ENTER = 4'hA;
  localparam logic [3:0] K_NEG   = 4'hB;
  localparam logic [3:0] K_ADD   = 4'hC;
  localparam logic [3:0] K_MUL   = 4'hD;
  localparam logic [3:0] K_CLR   = 4'hE;

  localparam logic [1:0] OP_NEG = 2'd1;

  typedef enum logic [1:0] {IDLE, ENTRY, OPPEND} state_t;

  state_t         state;
  logic [1:0]     pend_op;
  logic [DW-1:0]  entry_next_c;
  logic [1:0]     key_op_c;
  logic           push_full_c;

  // Negate needs one operand, add and multiply need two.
  function automatic logic op_ok(input logic [1:0] o, input logic [SW-1:0] dep);
    if (o == OP_NEG) op_ok = (dep >= SW'(1));
    else             op_ok = (dep >= SW'(2));
  endfunction

  assign entry_next_c = DW'(entry * DW'(10)) + DW'(key_code);
  assign key_op_c     = 2'(key_code - K_ENTER);
  assign push_full_c  = (depth == DEPTH_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend_op   <= 2'd0;
      entry     <= '0;
      depth     <= '0;
      cmd_valid <= 1'b0;
      push      <= 1'b0;
      op        <= 2'd0;
      d         <= '0;
      err       <= 1'b0;
      key_ready <= 1'b1;
    end else begin
      cmd_valid <= 1'b0;
      push      <= 1'b0;
      op        <= 2'd0;
      d         <= '0;
      err       <= 1'b0;
      key_ready <= 1'b1;

      case (state)
        // Second half of a push-then-op pair; depth already reflects the push.
        OPPEND: begin
          state <= IDLE;
          if (op_ok(pend_op, depth)) begin
            cmd_valid <= 1'b1;
            op        <= pend_op;
            if (pend_op != OP_NEG) depth <= depth - SW'(1);
          end else begin
            err <= 1'b1;
          end
        end

        default: begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              entry <= entry_next_c;
              state <= ENTRY;
            end else begin
              case (key_code)
                K_ENTER: begin
                  if (state == ENTRY) begin
                    if (push_full_c) begin
                      err <= 1'b1;
                    end else begin
                      cmd_valid <= 1'b1;
                      push      <= 1'b1;
                      d         <= entry;
                      depth     <= depth + SW'(1);
                    end
                    entry <= '0;
                    state <= IDLE;
                  end
                end
                K_NEG, K_ADD, K_MUL: begin
                  if (state == ENTRY) begin
                    if (push_full_c) begin
                      err <= 1'b1;
                    end else begin
                      cmd_valid <= 1'b1;
                      push      <= 1'b1;
                      d         <= entry;
                      depth     <= depth + SW'(1);
                    end
                    entry     <= '0;
                    pend_op   <= key_op_c;
                    state     <= OPPEND;
                    key_ready <= 1'b0;
                  end else if (op_ok(key_op_c, depth)) begin
                    cmd_valid <= 1'b1;
                    op        <= key_op_c;
                    if (key_op_c != OP_NEG) depth <= depth - SW'(1);
                  end else begin
                    err <= 1'b1;
                  end
                end
                K_CLR: begin
                  entry <= '0;
                  state <= IDLE;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_key_sequencer.sv
// Scoreboard bench for rpn_key_sequencer: expected commands/err pulses are queued by the
// stimulus thread and popped by a monitor whenever the DUT strobes cmd_valid or err.
module tb_rpn_key_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'hF;
  logic        key_ready;
  logic        cmd_valid;
  logic        push;
  logic [1:0]  op;
  logic [15:0] d;
  logic [15:0] entry;
  logic [9:0]  depth;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic        cv;
    logic        er;
    logic        pu;
    logic [1:0]  op;
    logic [15:0] d;
  } ev_t;

  ev_t exp_q[$];

  rpn_key_sequencer dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .cmd_valid(cmd_valid), .push(push), .op(op),
    .d(d), .entry(entry), .depth(depth), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void exp_push(input logic [15:0] v);
    exp_q.push_back('{cv: 1'b1, er: 1'b0, pu: 1'b1, op: 2'd0, d: v});
  endfunction

  function automatic void exp_op(input logic [1:0] o);
    exp_q.push_back('{cv: 1'b1, er: 1'b0, pu: 1'b0, op: o, d: 16'd0});
  endfunction

  function automatic void exp_err();
    exp_q.push_back('{cv: 1'b0, er: 1'b1, pu: 1'b0, op: 2'd0, d: 16'd0});
  endfunction

  // Monitor: every strobe must match the next queued expectation; idle cycles must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cmd_valid === 1'b1 || err === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {cmd_valid, err, push, op, d[11:0]}, 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event", {cmd_valid, err, push, op, d}, {11'd0, e});
        end
      end else begin
        chk("idle_outputs_zero", {push, op, d}, 32'd0);
      end
    end
  end

  task automatic send(input logic [3:0] k);
    int n;
    n = 0;
    while (key_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (key_ready !== 1'b1) chk("key_ready_timeout", 32'(key_ready), 32'd1);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'hF;
  endtask

  // A key is offered alongside reset to confirm it is ignored.
  task automatic do_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; key_valid = 1'b1; key_code = 4'd7;
    @(posedge clk);
    #1;
    rst = 1'b0; key_valid = 1'b0; key_code = 4'hF;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    mon_en = 1'b1;
    chk("rst_key_ready", 32'(key_ready), 32'd1);
    chk("rst_entry", 32'(entry), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // 1,2,Enter -> push 12
    send(4'd1); send(4'd2);
    chk("entry_12", 32'(entry), 32'd12);
    exp_push(16'd12);
    send(4'hA);
    chk("depth_after_push12", 32'(depth), 32'd1);
    chk("entry_after_push12", 32'(entry), 32'd0);

    // 3,Enter,4,Add -> push 3, push 4 + add back-to-back
    do_reset();
    exp_push(16'd3);
    send(4'd3); send(4'hA);
    exp_push(16'd4); exp_op(2'd2);
    send(4'd4); send(4'hC);
    chk("oppend_key_ready", 32'(key_ready), 32'd0);
    chk("oppend_depth", 32'(depth), 32'd2);
    @(posedge clk); #1;
    chk("after_add_key_ready", 32'(key_ready), 32'd1);
    chk("after_add_depth", 32'(depth), 32'd1);

    // Ops from IDLE: negate ok, add short of operands, then 8,Mul
    exp_op(2'd1);
    send(4'hB);
    chk("neg_idle_depth", 32'(depth), 32'd1);
    exp_err();
    send(4'hC);
    chk("add_fail_depth", 32'(depth), 32'd1);
    exp_push(16'd8); exp_op(2'd3);
    send(4'd8); send(4'hD);
    send(4'hF);
    send(4'hA);
    chk("ignored_keys_entry", 32'(entry), 32'd0);
    chk("after_mul_depth", 32'(depth), 32'd1);

    // Op from ENTRY with insufficient effective depth: push survives, add dropped
    do_reset();
    exp_push(16'd7); exp_err();
    send(4'd7); send(4'hC);
    @(posedge clk); #1;
    chk("entry_add_fail_depth", 32'(depth), 32'd1);

    // Negate from ENTRY at depth 0 uses the pending push as its operand
    do_reset();
    exp_push(16'd2); exp_op(2'd1);
    send(4'd2); send(4'hB);
    @(posedge clk); #1;
    chk("entry_neg_depth", 32'(depth), 32'd1);

    // Negate right after reset is rejected
    do_reset();
    exp_err();
    send(4'hB);
    chk("neg_empty_depth", 32'(depth), 32'd0);

    // Entry wrap-around: 65536 -> 0, 70000 -> 4464
    send(4'd6); send(4'd5); send(4'd5); send(4'd3);
    chk("entry_6553", 32'(entry), 32'd6553);
    send(4'd6);
    chk("entry_wrap_0", 32'(entry), 32'd0);
    send(4'hE);
    send(4'd7); send(4'd0); send(4'd0); send(4'd0); send(4'd0);
    chk("entry_wrap_4464", 32'(entry), 32'd4464);
    key_valid = 1'b0; key_code = 4'd3;
    @(posedge clk); #1;
    key_code = 4'hF;
    chk("invalid_key_entry", 32'(entry), 32'd4464);
    send(4'hE);
    chk("clear_entry", 32'(entry), 32'd0);
    send(4'hA);
    chk("enter_after_clear_depth", 32'(depth), 32'd0);

    // Fill stack to 1023, then a push is dropped
    do_reset();
    for (int i = 0; i < 1023; i++) begin
      exp_push(16'd1);
      send(4'd1); send(4'hA);
    end
    chk("full_depth", 32'(depth), 32'd1023);
    exp_err();
    send(4'd9); send(4'hA);
    chk("full_push_entry", 32'(entry), 32'd0);
    chk("full_push_depth", 32'(depth), 32'd1023);
    // Dropped push followed by an add that still has operands
    exp_err(); exp_op(2'd2);
    send(4'd4); send(4'hC);
    @(posedge clk); #1;
    chk("full_add_depth", 32'(depth), 32'd1022);

    // Reset during OPPEND discards the pending multiply
    do_reset();
    exp_push(16'd5);
    send(4'd5); send(4'hD);
    chk("pre_rst_push", {31'd0, push}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_oppend_outputs", {cmd_valid, err, push, op, d}, 32'd0);
    chk("rst_oppend_entry_depth", {entry, 6'd0, depth}, 32'd0);
    chk("rst_oppend_key_ready", 32'(key_ready), 32'd1);

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
